// File: rtl/dkong_dma_ctrl_if.sv
// Bus bundle for the programmable block-copy/fill DMA: CPU-side trigger/config,
// source RAM read port and destination RAM write port.
interface dkong_dma_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int LW = 10
);
    logic          I_TRIG;
    logic          I_ABORT;
    logic [AW-1:0] I_SRC_BASE;
    logic [AW-1:0] I_DST_BASE;
    logic [LW-1:0] I_LEN;
    logic          I_MODE;
    logic [DW-1:0] I_FILL;
    logic [DW-1:0] I_DMA_DS;
    logic [AW-1:0] O_DMA_AS;
    logic [AW-1:0] O_DMA_AD;
    logic [DW-1:0] O_DMA_DD;
    logic          O_DMA_CES;
    logic          O_DMA_CED;
    logic          O_DMA_WE;
    logic          O_BUSY;
    logic          O_DONE;
    logic          O_ABORTED;

    // DMA engine side
    modport slave (
        input  I_TRIG, I_ABORT, I_SRC_BASE, I_DST_BASE, I_LEN, I_MODE, I_FILL, I_DMA_DS,
        output O_DMA_AS, O_DMA_AD, O_DMA_DD, O_DMA_CES, O_DMA_CED, O_DMA_WE,
               O_BUSY, O_DONE, O_ABORTED
    );

    // CPU / memory side
    modport master (
        output I_TRIG, I_ABORT, I_SRC_BASE, I_DST_BASE, I_LEN, I_MODE, I_FILL, I_DMA_DS,
        input  O_DMA_AS, O_DMA_AD, O_DMA_DD, O_DMA_CES, O_DMA_CED, O_DMA_WE,
               O_BUSY, O_DONE, O_ABORTED
    );
endinterface

// File: rtl/dkong_dma_ctrl.sv
// Programmable single-channel copy/fill DMA. Each byte takes four cycles
// (RD, LAT, WR, NXT); geometry is latched on a rising trigger edge in IDLE.
module dkong_dma_ctrl #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int LW = 10
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    dkong_dma_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_NXT, S_DONE} state_t;

    state_t        st, st_n;
    logic          trig_hist;
    logic [AW-1:0] as_q, as_n, ad_q, ad_n;
    logic [DW-1:0] dd_q, dd_n, fill_q, fill_n;
    logic [LW-1:0] rem_q, rem_n;
    logic          mode_q, mode_n;
    logic          we_q, we_n, busy_q, busy_n, done_q, done_n, abt_q, abt_n;
    logic          start, active;

    assign start  = (st == S_IDLE) && !trig_hist && bus.I_TRIG;
    assign active = (st == S_RD) || (st == S_LAT) || (st == S_WR) || (st == S_NXT);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            st        <= S_IDLE;
            trig_hist <= 1'b1;   // a trigger held through reset must not start a transfer
            as_q      <= '0;
            ad_q      <= '0;
            dd_q      <= '0;
            fill_q    <= '0;
            rem_q     <= '0;
            mode_q    <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abt_q     <= 1'b0;
        end else begin
            st        <= st_n;
            trig_hist <= bus.I_TRIG;
            as_q      <= as_n;
            ad_q      <= ad_n;
            dd_q      <= dd_n;
            fill_q    <= fill_n;
            rem_q     <= rem_n;
            mode_q    <= mode_n;
            we_q      <= we_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            abt_q     <= abt_n;
        end
    end

    always_comb begin
        st_n   = st;
        as_n   = as_q;
        ad_n   = ad_q;
        dd_n   = dd_q;
        fill_n = fill_q;
        rem_n  = rem_q;
        mode_n = mode_q;
        we_n   = 1'b0;
        busy_n = busy_q;
        done_n = 1'b0;
        abt_n  = abt_q;
        case (st)
            S_IDLE: begin
                if (start) begin
                    as_n   = bus.I_SRC_BASE;
                    ad_n   = bus.I_DST_BASE;
                    rem_n  = bus.I_LEN;
                    mode_n = bus.I_MODE;
                    fill_n = bus.I_FILL;
                    abt_n  = 1'b0;
                    if (bus.I_LEN != '0) begin
                        st_n   = S_RD;
                        busy_n = 1'b1;
                    end else begin
                        st_n   = S_DONE;
                        done_n = 1'b1;
                    end
                end
            end
            S_RD:  st_n = S_LAT;
            S_LAT: begin
                st_n = S_WR;
                dd_n = mode_q ? fill_q : bus.I_DMA_DS;
                we_n = 1'b1;
            end
            S_WR:  st_n = S_NXT;
            S_NXT: begin
                ad_n  = ad_q + AW'(1);
                if (!mode_q)
                    as_n = as_q + AW'(1);
                rem_n = rem_q - LW'(1);
                if (rem_q == LW'(1)) begin
                    st_n   = S_DONE;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end else begin
                    st_n = S_RD;
                end
            end
            S_DONE:  st_n = S_IDLE;
            default: st_n = S_IDLE;
        endcase
        // Abort overrides everything in the busy states; a strobe already on the bus finishes.
        if (active && bus.I_ABORT) begin
            st_n   = S_DONE;
            we_n   = 1'b0;
            busy_n = 1'b0;
            done_n = 1'b1;
            abt_n  = 1'b1;
        end
    end

    assign bus.O_DMA_AS  = as_q;
    assign bus.O_DMA_AD  = ad_q;
    assign bus.O_DMA_DD  = dd_q;
    assign bus.O_DMA_CES = busy_q;
    assign bus.O_DMA_CED = busy_q;
    assign bus.O_DMA_WE  = we_q;
    assign bus.O_BUSY    = busy_q;
    assign bus.O_DONE    = done_q;
    assign bus.O_ABORTED = abt_q;
endmodule
